// File: rtl/align_pkg.sv
// Shared definitions for the alignment network, its controller and the packer.
package align_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int CNT_W      = 4;
    localparam int FILL_W     = 5;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH;

    typedef logic [CNT_W-1:0]  byte_cnt_t;
    typedef logic [FILL_W-1:0] fill_cnt_t;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    // Byte counts above one full word are treated as a full word.
    function automatic byte_cnt_t clamp_bytes(input byte_cnt_t count);
        if (count > byte_cnt_t'(BYTES)) begin
            return byte_cnt_t'(BYTES);
        end
        return count;
    endfunction

endpackage

// File: rtl/align_packer_byte_lane_mask.sv
// Turns a byte count into a keep mask over the low byte lanes of a word.
module byte_lane_mask
    import align_pkg::*;
(
    input  byte_cnt_t              count,
    output logic [DATA_WIDTH-1:0]  mask
);

    logic [BYTES-1:0] keep;

    // Lane i is kept when it lies below the count.
    always_comb begin
        keep = '0;
        for (int i = 0; i < BYTES; i++) begin
            keep[i] = (count > byte_cnt_t'(i));
        end
    end

    // Each kept lane becomes eight set bits of the data mask.
    always_comb begin
        mask = '0;
        for (int i = 0; i < BYTES; i++) begin
            mask[i*8 +: 8] = {8{keep[i]}};
        end
    end

endmodule

// File: rtl/align_packer.sv
// Packs aligned partial words into a dense stream of full words.
// Optional ALIGN_PACKER_BYTECNT_EN adds a saturating byte_total output.
module align_packer
    import align_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  byte_cnt_t              in_bytes,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output byte_cnt_t              out_bytes,
    output logic                   out_last
`ifdef ALIGN_PACKER_BYTECNT_EN
    ,
    output logic [31:0]            byte_total
`endif
);

    pack_state_t            state;
    pack_state_t            state_next;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic [ACC_WIDTH-1:0]   acc_base;
    fill_cnt_t              fill;
    fill_cnt_t              fill_next;
    fill_cnt_t              fill_base;
    byte_cnt_t              in_cnt;
    logic [DATA_WIDTH-1:0]  lane_mask;
    logic [DATA_WIDTH-1:0]  in_masked;
    logic                   accept;
    logic                   emit;

    assign in_cnt = clamp_bytes(in_bytes);

    byte_lane_mask u_lane_mask (
        .count (in_cnt),
        .mask  (lane_mask)
    );

    assign in_masked = in_data & lane_mask;

    assign in_ready  = rst_n && (state == FILL) && (fill <= fill_cnt_t'(BYTES));
    assign out_valid = (fill >= fill_cnt_t'(BYTES)) || (state == FLUSH);
    assign out_data  = acc[DATA_WIDTH-1:0];
    assign out_bytes = (fill >= fill_cnt_t'(BYTES)) ? byte_cnt_t'(BYTES) : fill[CNT_W-1:0];
    assign out_last  = (state == FLUSH) && (fill <= fill_cnt_t'(BYTES));

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    // Emit shifts the accumulator down first, then any accepted word is appended at the new fill.
    always_comb begin
        state_next = state;
        acc_base   = acc;
        fill_base  = fill;
        if (emit) begin
            acc_base  = acc >> DATA_WIDTH;
            fill_base = fill - fill_cnt_t'(out_bytes);
            if (out_last) begin
                state_next = FILL;
            end
        end
        acc_next  = acc_base;
        fill_next = fill_base;
        if (accept) begin
            acc_next  = acc_base | ({{DATA_WIDTH{1'b0}}, in_masked} << {fill_base, 3'b000});
            fill_next = fill_base + fill_cnt_t'(in_cnt);
            if (in_last) begin
                state_next = FLUSH;
            end
        end
    end

    // State register; reset drops buffered bytes and any pending last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator and fill count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            fill <= '0;
        end else begin
            acc  <= acc_next;
            fill <= fill_next;
        end
    end

`ifdef ALIGN_PACKER_BYTECNT_EN
    logic [32:0] total_sum;

    assign total_sum = {1'b0, byte_total} + 33'(out_bytes);

    // Running count of emitted bytes, sticking at all-ones once it overflows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_total <= '0;
        end else if (emit) begin
            byte_total <= total_sum[32] ? 32'hFFFF_FFFF : total_sum[31:0];
        end
    end
`endif

endmodule
